uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one uart_tx byte channel (valid/ready) among NUM_REQ requesters. Example requesters: the banner/string sender and the RX echo path.
- Grants are round-robin and message-granular. Once a requester is granted, it owns the channel until it transfers a byte flagged last.
- Sits between the message sources and the uart_tx instance. Drives uart_tx's tx_data/tx_data_valid and consumes its tx_data_ready.

Parameters:
- NUM_REQ, 2, number of requesters (legal 2..8).
- TIMEOUT_CYCLES, 27000000, stall limit in clock cycles (1 s at 27 MHz). Used only when UART_ARB_TIMEOUT_EN is defined.

Ports:
- clock  input  1  system clock
- rst_n  input  1  reset
- req_data  input  NUM_REQ*8  byte per requester; requester i occupies bits [i*8 +: 8]
- req_valid  input  NUM_REQ  byte valid per requester
- req_last  input  NUM_REQ  byte is the final byte of its message; qualified by req_valid
- req_ready  output  NUM_REQ  byte accepted by the arbiter
- grant  output  NUM_REQ  one-hot current owner; all zero when idle
- tx_data  output  8  byte to uart_tx
- tx_data_valid  output  1  byte valid to uart_tx
- tx_data_ready  input  1  uart_tx can accept a byte
- busy  output  1  a message is in progress, or an output byte is still pending

Behaviour:
- Reset: rst_n, asynchronous, active-low; clock clock. All of the following clear immediately, mid-operation included:
  - grant=0, tx_data=0, tx_data_valid=0, state=IDLE, rr pointer=0.
  - Any pending output byte is dropped.
- Output register: a one-entry holding register.
  - "room" = ~tx_data_valid | tx_data_ready.
  - tx_data_valid stays high and tx_data stays stable until tx_data_ready is seen high.
  - A byte is consumed on any cycle where tx_data_valid & tx_data_ready.
- States:
  - IDLE:
    - grant=0; req_ready=0.
    - If any req_valid is set, pick the first set bit searching upward from the rr pointer, wrapping modulo NUM_REQ.
    - Register the pick as one-hot grant and go to XFER. Arbitration costs one cycle.
    - If no req_valid is set, stay in IDLE.
  - XFER:
    - req_ready[g] = grant[g] & room. The ready is combinational from tx_data_ready. For non-granted requesters, req_ready=0.
    - On req_valid[g] & req_ready[g]: tx_data <= req_data[g], tx_data_valid <= 1. The byte appears on tx_data the cycle after the handshake.
    - If that byte has req_last[g] set: go to IDLE and set the rr pointer to (g+1) mod NUM_REQ.
    - The final byte may still be pending in the register while IDLE arbitrates the next message. The next byte is accepted only when room allows.
    - When room holds and no new byte is accepted, tx_data_valid <= 0.
- Throughput: sustains one byte per cycle when tx_data_ready is held high.
- Fairness: the owner of the previous message has lowest priority in the next arbitration.
- Simultaneous events: consume and accept in the same cycle is legal; the register is overwritten with no bubble.
- Mid-message behaviour:
  - req_valid of the owner may drop mid-message; the grant is held indefinitely unless the optional timeout is built.
  - Requests from other requesters are ignored while XFER is active.
- busy = (state==XFER) | tx_data_valid.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- Defined:
  - A 32-bit stall counter clears on each accepted byte and on entry to XFER.
  - It increments on XFER cycles with no accepted byte.
  - When it reaches TIMEOUT_CYCLES - 1, the arbiter forces IDLE and advances the rr pointer past the owner, with no last byte required.
  - A sticky output timeout_flag (1 bit, reset 0, cleared on the next accepted byte) is added to the port list.
- Undefined: no counter and no timeout_flag port; the grant is released only by req_last.

Decomposition:
- Package uart_arb_pkg:
  - state localparams: IDLE=0, XFER=1
  - pointer-width constant PTR_W = clog2(NUM_REQ) and the clog2 function
  - default TIMEOUT constant
- Sub-module uart_rr_pick: purely combinational round-robin picker.
  - Inputs: req vector and pointer.
  - Outputs: one-hot pick and its index.
  - Instantiated once by uart_tx_arbiter.

Test Plan:
- Single requester: NUM_REQ=2, req0 sends 3 bytes 0x41,0x42,0x43 (last on 0x43), tx_data_ready=1 -> tx_data sequence 41,42,43 on consecutive cycles starting 2 cycles after req_valid rises; grant=01 throughout; then grant=00 and pointer=1.
- Contention: req0 and req1 both valid with 2-byte messages -> req0's message completes first, then req1's; req0 gets no bytes interleaved with req1's; the next tie goes to req0.
- Backpressure: tx_data_ready low for 10 cycles while a byte is pending -> tx_data_valid and tx_data are stable; req_ready[g]=0; the byte is consumed on the first cycle tx_data_ready is high.
- Wrap-around: NUM_REQ=3, pointer=2, req0 and req1 valid -> req0 is granted (wraps past index 2).
- Reset mid-message: rst_n low during byte 2 of 4 -> outputs are zero immediately; after release, IDLE arbitrates afresh from pointer 0.
- Timeout (UART_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16): owner stops after byte 1 with no last -> grant drops after 16 idle cycles, timeout_flag=1, and a waiting req1 is granted next.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the uart_tx arbiter slice.
// Optional stall timeout is built when UART_ARB_TIMEOUT_EN is defined.
package uart_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } arb_state_e;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) r = r + 1;
      return (r == 0) ? 1 : r;
   endfunction

   // Pointer width covers the largest legal requester count, so one width serves every build.
   localparam int unsigned NUM_REQ_MAX        = 8;
   localparam int unsigned PTR_W              = clog2(NUM_REQ_MAX);
   localparam int unsigned DEF_TIMEOUT_CYCLES = 27_000_000;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping.
module uart_rr_pick
   import uart_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [PTR_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] pick_o,
   output logic [PTR_W-1:0]   idx_o
);

   logic [2*NUM_REQ-1:0] dbl;
   logic [NUM_REQ-1:0]   rot;
   logic [PTR_W:0]       sum;
   logic                 found;

   always_comb begin
      dbl    = {req_i, req_i} >> ptr_i;
      rot    = dbl[NUM_REQ-1:0];
      sum    = '0;
      found  = 1'b0;
      idx_o  = '0;
      pick_o = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (!found && rot[k]) begin
            found = 1'b1;
            sum   = {1'b0, ptr_i} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NUM_REQ)) sum = sum - (PTR_W+1)'(NUM_REQ);
         end
      end
      if (found) begin
         idx_o  = sum[PTR_W-1:0];
         pick_o = NUM_REQ'(1) << idx_o;
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter sharing one uart_tx byte channel.
// Define UART_ARB_TIMEOUT_EN to add the stall timeout and timeout_flag port.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ        = 2,
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                 clock,
   input  logic                 rst_n,
   input  logic [NUM_REQ*8-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [NUM_REQ-1:0]   grant,
   output logic [7:0]           tx_data,
   output logic                 tx_data_valid,
   input  logic                 tx_data_ready,
   output logic                 busy
`ifdef UART_ARB_TIMEOUT_EN
   ,
   output logic                 timeout_flag
`endif
);

   arb_state_e         state_q;
   logic [NUM_REQ-1:0] grant_q;
   logic [PTR_W-1:0]   gidx_q;
   logic [PTR_W-1:0]   ptr_q;
   logic [7:0]         tx_data_q;
   logic               tx_valid_q;

   logic [NUM_REQ-1:0] pick;
   logic [PTR_W-1:0]   pick_idx;
   logic               room;
   logic               accept;
   logic [7:0]         acc_byte;
   logic               acc_last;
   logic [PTR_W-1:0]   ptr_next;

   uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req_i  (req_valid),
      .ptr_i  (ptr_q),
      .pick_o (pick),
      .idx_o  (pick_idx)
   );

   assign room     = ~tx_valid_q | tx_data_ready;
   assign accept   = (state_q == XFER) & room & (|(req_valid & grant_q));
   assign ptr_next = (gidx_q == PTR_W'(NUM_REQ-1)) ? '0 : gidx_q + PTR_W'(1);

   // grant_q is one-hot, so an OR across requesters is the owner's byte.
   always_comb begin
      acc_byte = '0;
      acc_last = 1'b0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (grant_q[k]) begin
            acc_byte = acc_byte | req_data[k*8 +: 8];
            acc_last = acc_last | req_last[k];
         end
      end
   end

`ifdef UART_ARB_TIMEOUT_EN
   logic [31:0] stall_q;
   logic        tflag_q;
   assign timeout_flag = tflag_q;
`else
   logic unused_timeout;
   assign unused_timeout = |32'(TIMEOUT_CYCLES);
`endif

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         gidx_q     <= '0;
         ptr_q      <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
         stall_q    <= '0;
         tflag_q    <= 1'b0;
`endif
      end else begin
         if (room) tx_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (|req_valid) begin
                  grant_q <= pick;
                  gidx_q  <= pick_idx;
                  state_q <= XFER;
`ifdef UART_ARB_TIMEOUT_EN
                  stall_q <= '0;
`endif
               end
            end
            XFER: begin
               if (accept) begin
                  tx_data_q  <= acc_byte;
                  tx_valid_q <= 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
                  stall_q    <= '0;
                  tflag_q    <= 1'b0;
`endif
                  if (acc_last) begin
                     state_q <= IDLE;
                     grant_q <= '0;
                     ptr_q   <= ptr_next;
                  end
               end
`ifdef UART_ARB_TIMEOUT_EN
               else if (stall_q == 32'(TIMEOUT_CYCLES - 1)) begin
                  state_q <= IDLE;
                  grant_q <= '0;
                  ptr_q   <= ptr_next;
                  tflag_q <= 1'b1;
               end else begin
                  stall_q <= stall_q + 32'd1;
               end
`endif
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready     = ((state_q == XFER) && room) ? grant_q : '0;
   assign grant         = grant_q;
   assign tx_data       = tx_data_q;
   assign tx_data_valid = tx_valid_q;
   assign busy          = (state_q == XFER) | tx_valid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table, directed corner cases,
// and randomized traffic checked against a message-level round-robin model.
module tb_uart_tx_arbiter;

   localparam int N = 3;

   logic           clock = 1'b0;
   logic           rst_n = 1'b0;
   logic [N*8-1:0] req_data = '0;
   logic [N-1:0]   req_valid = '0;
   logic [N-1:0]   req_last = '0;
   logic [N-1:0]   req_ready;
   logic [N-1:0]   grant;
   logic [7:0]     tx_data;
   logic           tx_data_valid;
   logic           tx_data_ready = 1'b1;
   logic           busy;
`ifdef UART_ARB_TIMEOUT_EN
   logic           timeout_flag;
`endif

   uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
      .clock         (clock),
      .rst_n         (rst_n),
      .req_data      (req_data),
      .req_valid     (req_valid),
      .req_last      (req_last),
      .req_ready     (req_ready),
      .grant         (grant),
      .tx_data       (tx_data),
      .tx_data_valid (tx_data_valid),
      .tx_data_ready (tx_data_ready),
      .busy          (busy)
`ifdef UART_ARB_TIMEOUT_EN
      ,
      .timeout_flag  (timeout_flag)
`endif
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int model_ptr = 0;

   logic [8:0] src_q [N][$];
   logic [8:0] drv_q [N][$];
   logic [7:0] exp_q [$];
   logic [7:0] out_q [$];

   typedef struct {
      logic [N-1:0] v;
      logic [N-1:0] l;
      logic [7:0]   d0;
      logic         txr;
      logic [N-1:0] g;
      logic [N-1:0] rdy;
      logic         txv;
      logic [7:0]   txd;
      logic         bsy;
   } vec_t;

   vec_t tv [6];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic idle_in();
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
   endtask

   task automatic set_req(input int i, input logic [7:0] d, input logic l);
      req_data[i*8 +: 8] = d;
      req_last[i]        = l;
   endtask

   task automatic do_reset();
      idle_in();
      tx_data_ready = 1'b1;
      rst_n = 1'b0;
      @(posedge clock); #1;
      rst_n = 1'b1;
      model_ptr = 0;
   endtask

   // Message-level reference: next owner is the first requester with a
   // pending message at or after the pointer; its whole message goes out.
   task automatic build_expected();
      logic [8:0] tmp [N][$];
      int sel;
      logic done;
      exp_q.delete();
      for (int i = 0; i < N; i++) tmp[i] = src_q[i];
      forever begin
         sel = -1;
         for (int k = 0; k < N; k++)
            if (sel < 0 && tmp[(model_ptr + k) % N].size() > 0) sel = (model_ptr + k) % N;
         if (sel < 0) break;
         done = 1'b0;
         while (!done) begin
            exp_q.push_back(tmp[sel][0][7:0]);
            done = tmp[sel][0][8];
            void'(tmp[sel].pop_front());
         end
         model_ptr = (sel + 1) % N;
      end
   endtask

   task automatic run_engine(input int rdy_pct, input int gap_pct, input int budget, input string tag);
      logic       mid [N];
      int         cyc;
      logic       prev_stall;
      logic [7:0] prev_d;
      build_expected();
      for (int i = 0; i < N; i++) begin
         drv_q[i] = src_q[i];
         src_q[i].delete();
         mid[i] = 1'b0;
      end
      out_q.delete();
      cyc = 0;
      prev_stall = 1'b0;
      prev_d = '0;
      @(posedge clock); #1;
      while (out_q.size() < exp_q.size() && cyc < budget) begin
         for (int i = 0; i < N; i++) begin
            if (drv_q[i].size() > 0) begin
               set_req(i, drv_q[i][0][7:0], drv_q[i][0][8]);
               req_valid[i] = !(mid[i] && ($urandom_range(0, 99) < gap_pct));
            end else begin
               set_req(i, 8'h00, 1'b0);
               req_valid[i] = 1'b0;
            end
         end
         tx_data_ready = ($urandom_range(0, 99) < rdy_pct);
         @(negedge clock);
         chk({tag, "_grant_onehot"}, 32'($onehot0(grant)), 32'd1);
         if (prev_stall) begin
            chk({tag, "_hold_valid"}, 32'(tx_data_valid), 32'd1);
            chk({tag, "_hold_data"}, 32'(tx_data), 32'(prev_d));
         end
         for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               mid[i] = !drv_q[i][0][8];
               void'(drv_q[i].pop_front());
            end
         end
         if (tx_data_valid && tx_data_ready) out_q.push_back(tx_data);
         prev_stall = tx_data_valid & ~tx_data_ready;
         prev_d = tx_data;
         @(posedge clock); #1;
         cyc++;
      end
      chk({tag, "_count"}, 32'(out_q.size()), 32'(exp_q.size()));
      for (int k = 0; k < exp_q.size() && k < out_q.size(); k++)
         chk({tag, "_byte"}, 32'(out_q[k]), 32'(exp_q[k]));
      idle_in();
      tx_data_ready = 1'b1;
      @(negedge clock);
      chk({tag, "_end_busy"}, 32'(busy), 32'd0);
      chk({tag, "_end_grant"}, 32'(grant), 32'd0);
   endtask

   task automatic push_msg(input int i, input int len);
      for (int b = 0; b < len; b++)
         src_q[i].push_back({(b == len - 1), 8'($urandom_range(0, 255))});
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      logic [7:0] lit [8];

      tv[0] = '{v:3'b001, l:3'b000, d0:8'h41, txr:1'b1, g:3'b000, rdy:3'b000, txv:1'b0, txd:8'h00, bsy:1'b0};
      tv[1] = '{v:3'b001, l:3'b000, d0:8'h41, txr:1'b1, g:3'b001, rdy:3'b001, txv:1'b0, txd:8'h00, bsy:1'b1};
      tv[2] = '{v:3'b001, l:3'b000, d0:8'h42, txr:1'b1, g:3'b001, rdy:3'b001, txv:1'b1, txd:8'h41, bsy:1'b1};
      tv[3] = '{v:3'b001, l:3'b001, d0:8'h43, txr:1'b1, g:3'b001, rdy:3'b001, txv:1'b1, txd:8'h42, bsy:1'b1};
      tv[4] = '{v:3'b000, l:3'b000, d0:8'h00, txr:1'b1, g:3'b000, rdy:3'b000, txv:1'b1, txd:8'h43, bsy:1'b1};
      tv[5] = '{v:3'b000, l:3'b000, d0:8'h00, txr:1'b1, g:3'b000, rdy:3'b000, txv:1'b0, txd:8'h43, bsy:1'b0};

      do_reset();
      @(negedge clock);
      chk("reset_grant", 32'(grant), 32'd0);
      chk("reset_txv", 32'(tx_data_valid), 32'd0);
      chk("reset_txd", 32'(tx_data), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_ready", 32'(req_ready), 32'd0);

      // Single requester: req0 sends 41,42,43.
      for (int r = 0; r < 6; r++) begin
         @(posedge clock); #1;
         req_valid = tv[r].v;
         req_last  = tv[r].l;
         req_data  = {{((N-1)*8){1'b0}}, tv[r].d0};
         tx_data_ready = tv[r].txr;
         @(negedge clock);
         chk($sformatf("vec%0d_grant", r), 32'(grant), 32'(tv[r].g));
         chk($sformatf("vec%0d_ready", r), 32'(req_ready), 32'(tv[r].rdy));
         chk($sformatf("vec%0d_txv", r), 32'(tx_data_valid), 32'(tv[r].txv));
         chk($sformatf("vec%0d_txd", r), 32'(tx_data), 32'(tv[r].txd));
         chk($sformatf("vec%0d_busy", r), 32'(busy), 32'(tv[r].bsy));
      end

      // Backpressure: byte 5A held for 10 cycles, then consumed while 5B is accepted.
      @(posedge clock); #1;
      req_valid = 3'b001;
      set_req(0, 8'h5A, 1'b0);
      tx_data_ready = 1'b0;
      @(negedge clock);
      chk("bp_arb_grant", 32'(grant), 32'd0);
      @(posedge clock); #1;
      @(negedge clock);
      chk("bp_first_ready", 32'(req_ready), 32'b001);
      @(posedge clock); #1;
      set_req(0, 8'h5B, 1'b1);
      repeat (10) begin
         @(negedge clock);
         chk("bp_stall_txv", 32'(tx_data_valid), 32'd1);
         chk("bp_stall_txd", 32'(tx_data), 32'h5A);
         chk("bp_stall_ready", 32'(req_ready), 32'd0);
         @(posedge clock); #1;
      end
      tx_data_ready = 1'b1;
      @(negedge clock);
      chk("bp_release_ready", 32'(req_ready), 32'b001);
      chk("bp_release_txd", 32'(tx_data), 32'h5A);
      @(posedge clock); #1;
      idle_in();
      @(negedge clock);
      chk("bp_overwrite_txd", 32'(tx_data), 32'h5B);
      chk("bp_overwrite_txv", 32'(tx_data_valid), 32'd1);
      chk("bp_done_grant", 32'(grant), 32'd0);
      @(posedge clock); #1;
      @(negedge clock);
      chk("bp_drain_txv", 32'(tx_data_valid), 32'd0);
      chk("bp_drain_busy", 32'(busy), 32'd0);

      // Reset mid-message: req1 (pointer now 1) sends 11,12,13,14; reset during byte 2.
      @(posedge clock); #1;
      req_valid = 3'b010;
      set_req(1, 8'h11, 1'b0);
      @(posedge clock); #1;
      @(posedge clock); #1;
      set_req(1, 8'h12, 1'b0);
      @(negedge clock);
      chk("rst_mid_byte1", 32'(tx_data), 32'h11);
      @(posedge clock); #1;
      set_req(1, 8'h13, 1'b0);
      @(negedge clock);
      chk("rst_mid_byte2", 32'(tx_data), 32'h12);
      chk("rst_mid_grant", 32'(grant), 32'b010);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_txv", 32'(tx_data_valid), 32'd0);
      chk("rst_async_txd", 32'(tx_data), 32'd0);
      chk("rst_async_grant", 32'(grant), 32'd0);
      chk("rst_async_busy", 32'(busy), 32'd0);
      chk("rst_async_ready", 32'(req_ready), 32'd0);
      @(posedge clock); #1;
      rst_n = 1'b1;
      req_valid = 3'b111;
      req_last  = 3'b000;
      req_data  = {8'h33, 8'h22, 8'h11};
      @(negedge clock);
      chk("rst_after_idle", 32'(grant), 32'd0);
      @(posedge clock); #1;
      @(negedge clock);
      chk("rst_after_ptr0", 32'(grant), 32'b001);
      do_reset();

      // Contention and wrap: req0 and req1 each queue two 2-byte messages.
      src_q[0].push_back(9'h0A0); src_q[0].push_back(9'h1A1);
      src_q[0].push_back(9'h0C0); src_q[0].push_back(9'h1C1);
      src_q[1].push_back(9'h0B0); src_q[1].push_back(9'h1B1);
      src_q[1].push_back(9'h0D0); src_q[1].push_back(9'h1D1);
      run_engine(100, 0, 200, "cont");
      lit = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hC0, 8'hC1, 8'hD0, 8'hD1};
      for (int k = 0; k < 8 && k < out_q.size(); k++)
         chk("cont_order", 32'(out_q[k]), 32'(lit[k]));

      // Randomized traffic with gaps and backpressure.
      for (int rnd = 0; rnd < 8; rnd++) begin
         for (int i = 0; i < N; i++) begin
            int nm;
            nm = $urandom_range(0, 2);
            for (int m = 0; m < nm; m++) push_msg(i, $urandom_range(1, 4));
         end
         run_engine(70, 30, 2000, $sformatf("rand%0d", rnd));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
